// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronises and filters the PS/2 pins, deserialises
// 11-bit device-to-host frames and publishes good bytes with a rolling sequence count.
module ps2_keyboard_rx #(
   parameter int FILT_LEN       = 8,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_dat,
   output logic [7:0] scan_code,
   output logic [7:0] code_seq,
   output logic       code_valid,
   output logic       frame_err
);

   localparam int FW = $clog2(FILT_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   logic          clk_meta, clk_sync;
   logic          dat_meta, dat_sync;
   logic          filt_clk;
   logic [FW-1:0] filt_cnt;
   logic          fall;
   state_t        state;
   logic [2:0]    bit_cnt;
   logic [7:0]    shreg;
   logic          par_ok;
   logic [TW-1:0] tcnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clk_meta <= 1'b1;
         clk_sync <= 1'b1;
         dat_meta <= 1'b1;
         dat_sync <= 1'b1;
      end else begin
         clk_meta <= ps2_clk;
         clk_sync <= clk_meta;
         dat_meta <= ps2_dat;
         dat_sync <= dat_meta;
      end
   end

   // A new level is accepted on its FILT_LEN-th consecutive sample; the strobe
   // is raised in the same edge that commits a 1->0 change.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         filt_clk <= 1'b1;
         filt_cnt <= '0;
         fall     <= 1'b0;
      end else if (clk_sync == filt_clk) begin
         filt_cnt <= '0;
         fall     <= 1'b0;
      end else if (filt_cnt == FW'(FILT_LEN - 1)) begin
         filt_clk <= clk_sync;
         filt_cnt <= '0;
         fall     <= filt_clk;
      end else begin
         filt_cnt <= filt_cnt + 1'b1;
         fall     <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         shreg      <= '0;
         par_ok     <= 1'b0;
         tcnt       <= '0;
         scan_code  <= '0;
         code_seq   <= '0;
         code_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         code_valid <= 1'b0;
         frame_err  <= 1'b0;
         if (fall) begin
            // A strobe always wins over a simultaneous timeout.
            tcnt <= '0;
            case (state)
               IDLE: begin
                  if (!dat_sync) begin
                     state   <= DATA;
                     bit_cnt <= '0;
                  end
               end
               DATA: begin
                  shreg   <= {dat_sync, shreg[7:1]};
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == 3'd7)
                     state <= PARITY;
               end
               PARITY: begin
                  par_ok <= (^shreg) ^ dat_sync;
                  state  <= STOP;
               end
               STOP: begin
                  if (dat_sync && par_ok) begin
                     scan_code  <= shreg;
                     code_seq   <= code_seq + 1'b1;
                     code_valid <= 1'b1;
                  end else begin
                     frame_err  <= 1'b1;
                  end
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end else if (state == IDLE) begin
            tcnt <= '0;
         end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            state     <= IDLE;
            frame_err <= 1'b1;
            tcnt      <= '0;
         end else begin
            tcnt <= tcnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Bench for ps2_keyboard_rx: drives PS/2 frames on the pins and compares every
// code_valid / frame_err pulse against a frame-level reference model.
module tb_ps2_keyboard_rx;

   localparam int FILT = 8;
   localparam int TO   = 600;
   localparam int H    = 10;   // PS/2 half period in clk cycles
   localparam int SETTLE = 24;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_dat = 1'b1;
   logic [7:0] scan_code;
   logic [7:0] code_seq;
   logic       code_valid;
   logic       frame_err;

   ps2_keyboard_rx #(.FILT_LEN(FILT), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
      .scan_code(scan_code), .code_seq(code_seq),
      .code_valid(code_valid), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {int at; logic [7:0] sc; logic [7:0] sq;} ev_t;
   typedef struct {bit good; logic [7:0] b; logic [7:0] seq; int at;} exp_t;
   ev_t  vq[$];
   int   eq[$];
   exp_t xq[$];

   always @(negedge clk) begin
      if (!reset) begin
         if (code_valid) vq.push_back('{cyc, scan_code, code_seq});
         if (frame_err)  eq.push_back(cyc);
      end
   end

   int         tests = 0;
   int         fails = 0;
   int         lat   = -1;
   logic [7:0] mseq  = 8'h00;

   task automatic check(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d (0x%0h) required %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   task automatic bit_out(input logic d, output int fall_at);
      @(posedge clk); #2;
      ps2_dat = d;
      repeat (H) @(posedge clk);
      #2;
      ps2_clk = 1'b0;
      fall_at = cyc;
      repeat (H) @(posedge clk);
      #2;
      ps2_clk = 1'b1;
   endtask

   function automatic logic odd_par(input logic [7:0] b);
      return ~(^b);
   endfunction

   task automatic send_frame(input logic [7:0] b, input logic par, input logic stp, input string what);
      int  f;
      bit  good;
      bit_out(1'b0, f);
      for (int i = 0; i < 8; i++) bit_out(b[i], f);
      bit_out(par, f);
      bit_out(stp, f);
      ps2_dat = 1'b1;
      good = (((^b) ^ par) == 1'b1) && stp;
      if (good) mseq = mseq + 8'd1;
      xq.push_back('{good, b, mseq, f});
      $display("[TB] %s: byte=%02h par=%0b stop=%0b expect %s seq=%02h",
               what, b, par, stp, good ? "code" : "frame_err", mseq);
   endtask

   task automatic settle(input string tag);
      exp_t x;
      ev_t  v;
      int   e;
      repeat (SETTLE) @(posedge clk);
      @(negedge clk); #1;
      while (xq.size() != 0) begin
         x = xq.pop_front();
         if (x.good) begin
            check({tag, "_valid_seen"}, int'(vq.size() != 0), 1);
            if (vq.size() != 0) begin
               v = vq.pop_front();
               if (lat < 0) lat = v.at - x.at;
               check({tag, "_scan_code"}, int'(v.sc), int'(x.b));
               check({tag, "_code_seq"}, int'(v.sq), int'(x.seq));
               check({tag, "_latency"}, v.at - x.at, lat);
            end
         end else begin
            check({tag, "_err_seen"}, int'(eq.size() != 0), 1);
            if (eq.size() != 0) begin
               e = eq.pop_front();
               check({tag, "_err_latency"}, e - x.at, lat);
            end
         end
      end
      check({tag, "_no_extra_valid"}, vq.size(), 0);
      check({tag, "_no_extra_err"}, eq.size(), 0);
      check({tag, "_held_scan_seq"}, int'(code_seq), int'(mseq));
      vq.delete();
      eq.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_scan_code"}, int'(scan_code), 0);
      check({tag, "_code_seq"}, int'(code_seq), 0);
      check({tag, "_code_valid"}, int'(code_valid), 0);
      check({tag, "_frame_err"}, int'(frame_err), 0);
   endtask

   initial begin
      logic [7:0] b;
      logic       p;
      logic       s;
      int         f;

      #1;
      check_reset_outputs("reset");
      repeat (5) @(posedge clk);
      @(negedge clk); reset = 1'b0;
      repeat (5) @(posedge clk);

      // Basic good frame, then a back-to-back pair
      send_frame(8'h1C, 1'b0, 1'b1, "good_1c");
      settle("good_1c");
      send_frame(8'hF0, 1'b1, 1'b1, "b2b_f0");
      send_frame(8'h1C, 1'b0, 1'b1, "b2b_1c");
      settle("b2b");
      check("b2b_final_seq", int'(code_seq), 3);

      // Bad parity and bad stop
      send_frame(8'h1C, 1'b1, 1'b1, "bad_parity");
      settle("bad_parity");
      check("bad_parity_scan_kept", int'(scan_code), 8'h1C);
      send_frame(8'h1C, 1'b0, 1'b0, "bad_stop");
      settle("bad_stop");
      check("bad_stop_scan_kept", int'(scan_code), 8'h1C);

      // Clock stops after 4 data bits: abandoned TO cycles after the last strobe
      bit_out(1'b0, f);
      for (int i = 0; i < 4; i++) bit_out(1'(i & 1), f);
      ps2_dat = 1'b1;
      xq.push_back('{1'b0, 8'h00, mseq, f + TO});
      $display("[TB] timeout: clock stopped after 4 data bits, expect frame_err");
      repeat (TO) @(posedge clk);
      settle("timeout");
      send_frame(8'h29, odd_par(8'h29), 1'b1, "after_timeout");
      settle("after_timeout");
      check("after_timeout_scan", int'(scan_code), 8'h29);

      // 3-cycle glitch with data low must not start a frame
      @(posedge clk); #2;
      ps2_dat = 1'b0;
      ps2_clk = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      ps2_clk = 1'b1;
      ps2_dat = 1'b1;
      $display("[TB] glitch: 3-cycle low pulse on ps2_clk, expect no event");
      repeat (2 * H) @(posedge clk);
      send_frame(8'h5A, odd_par(8'h5A), 1'b1, "after_glitch");
      settle("after_glitch");

      // Reset in the middle of a frame
      bit_out(1'b0, f);
      for (int i = 0; i < 4; i++) bit_out(1'b1, f);
      @(negedge clk); #2;
      reset = 1'b1;
      #1;
      $display("[TB] reset asserted mid-frame");
      check_reset_outputs("midreset");
      ps2_dat = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk); reset = 1'b0;
      mseq = 8'h00;
      xq.delete(); vq.delete(); eq.delete();
      send_frame(8'h1C, 1'b0, 1'b1, "after_reset");
      settle("after_reset");

      // Random mix of good and corrupted frames
      for (int n = 0; n < 20; n++) begin
         b = 8'($urandom);
         p = odd_par(b) ^ ($urandom_range(0, 3) == 0);
         s = ($urandom_range(0, 7) != 0);
         send_frame(b, p, s, "random");
         settle("random");
      end

      // 256 good frames from reset: code_seq wraps
      @(negedge clk); reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk); reset = 1'b0;
      mseq = 8'h00;
      for (int n = 1; n <= 256; n++) begin
         b = 8'($urandom);
         send_frame(b, odd_par(b), 1'b1, "wrap");
         if (n % 16 == 0 || n == 255) settle("wrap");
         if (n == 255) check("wrap_seq_ff", int'(code_seq), 8'hFF);
      end
      check("wrap_seq_00", int'(code_seq), 8'h00);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
